// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type, timing constants and sizing helper for the key reader.
package key_pkg;
  typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE} key_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_RATE     = 5_000_000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY    = 10;
  localparam int SIM_REPEAT_RATE     = 3;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: synchronise, debounce and auto-repeat one active-low key, counting presses.
module key_debounce_fsm
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n_i,
  input  logic             repeat_en_i,
  output logic             level_o,
  output logic             press_o,
  output logic             release_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int TW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE));
  localparam logic [TW-1:0] DEB_LAST = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);
  logic [1:0]       sync_q;
  key_state_t       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             level_q, level_d, press_q, press_d, release_q, release_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             s;
  assign s = sync_q[1];
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        state_d = s ? DEB_PRESS : IDLE;
      end
      DEB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = HELD;
          timer_d = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = DEB_RELEASE;
          timer_d = '0;
        end else if (!repeat_en_i) begin
          timer_d = '0;
        end else if (timer_q == DLY_LAST) begin
          state_d = REPEAT;
          timer_d = '0;
          press_d = 1'b1;
        end
      end
      REPEAT: begin
        if (!s) begin
          state_d = DEB_RELEASE;
          timer_d = '0;
        end else if (!repeat_en_i) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == RATE_LAST) begin
          timer_d = '0;
          press_d = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (s) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d   = IDLE;
          timer_d   = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    count_d = count_q + CNT_W'(press_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], ~key_n_i};
      state_q   <= state_d;
      timer_q   <= timer_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end
  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign count_o   = count_q;
endmodule

// File: rtl/key_input_reader.sv
// key_input_reader: one debounce/repeat/count channel per KEY line, outputs packed into vectors.
module key_input_reader
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NUM_KEYS-1:0]       KEY,
  input  logic                      repeat_en,
  output logic [NUM_KEYS-1:0]       key_level,
  output logic [NUM_KEYS-1:0]       key_press,
  output logic [NUM_KEYS-1:0]       key_release,
  output logic [NUM_KEYS*CNT_W-1:0] press_count
);
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk        (CLOCK_50),
      .rst        (reset),
      .key_n_i    (KEY[g]),
      .repeat_en_i(repeat_en),
      .level_o    (key_level[g]),
      .press_o    (key_press[g]),
      .release_o  (key_release[g]),
      .count_o    (press_count[g*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_key_input_reader.sv
// tb_key_input_reader: run-length reference model feeds an event scoreboard checked by a monitor.
module tb_key_input_reader;
  import key_pkg::*;
  localparam int NK = 4, CW = 4;
  localparam int D = SIM_DEBOUNCE_CYCLES, RD = SIM_REPEAT_DELAY, RR = SIM_REPEAT_RATE;
  logic clk = 1'b0, reset = 1'b1, repeat_en = 1'b0;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] key_level, key_press, key_release;
  logic [NK*CW-1:0] press_count;
  always #5 clk = ~clk;
  key_input_reader #(
    .NUM_KEYS(NK), .CNT_W(CW), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(key), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .press_count(press_count)
  );
  int checks = 0, errors = 0, cyc = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask
  typedef struct {int cyc; logic [NK-1:0] press; logic [NK-1:0] rel;} ev_t;
  ev_t q[$];
  // Model: s is ~KEY two edges late; presses/releases follow run lengths of s.
  logic [1:0] sh[NK];
  logic sp[NK];
  int r1[NK], r0[NK], rr[NK];
  bit first[NK];
  logic [NK-1:0] exp_level = '0;
  logic [CW-1:0] exp_cnt[NK];
  always @(posedge clk) begin
    logic [NK-1:0] p, r;
    logic s;
    cyc++;
    p = '0;
    r = '0;
    for (int i = 0; i < NK; i++) begin
      if (reset) begin
        sh[i] = '0; sp[i] = 1'b0; r1[i] = 0; r0[i] = 0; rr[i] = 0; first[i] = 1'b1;
        exp_level[i] = 1'b0; exp_cnt[i] = '0;
      end else begin
        s = sh[i][1];
        if (!exp_level[i]) begin
          r1[i] = s ? r1[i] + 1 : 0;
          if (r1[i] == D + 1) begin
            p[i] = 1'b1; exp_level[i] = 1'b1; r1[i] = 0; r0[i] = 0; rr[i] = 0; first[i] = 1'b1;
          end
        end else begin
          r0[i] = s ? 0 : r0[i] + 1;
          if (r0[i] == D + 1) begin
            r[i] = 1'b1; exp_level[i] = 1'b0; r0[i] = 0; r1[i] = 0;
          end
          if (s && sp[i] && repeat_en) rr[i]++;
          else begin rr[i] = 0; first[i] = 1'b1; end
          if (rr[i] == (first[i] ? RD : RR)) begin
            p[i] = 1'b1; rr[i] = 0; first[i] = 1'b0;
          end
        end
        if (p[i]) exp_cnt[i] = exp_cnt[i] + 1'b1;
        sp[i] = s;
        sh[i] = {sh[i][0], ~key[i]};
      end
    end
    if (|{p, r}) q.push_back('{cyc, p, r});
  end
  always @(negedge clk) begin
    logic [NK*CW-1:0] ec;
    ev_t e;
    for (int i = 0; i < NK; i++) ec[i*CW +: CW] = exp_cnt[i];
    chk("level", key_level, exp_level);
    chk("count", press_count, ec);
    if (|{key_press, key_release}) begin
      if (q.size() == 0) chk("unexpected_pulse", {key_press, key_release}, 0);
      else begin
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("press", key_press, e.press);
        chk("release", key_release, e.rel);
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("missed_pulse", {key_press, key_release}, {e.press, e.rel});
    end
  end
  task automatic measure(input int idx, output int n);
    n = 0;
    @(posedge clk);
    repeat (40) begin
      @(posedge clk);
      n++;
      #1;
      if (key_press[idx]) return;
    end
    n = -1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int n;
    reset = 1'b1;
    idle(3);
    chk("rst_level", key_level, 0);
    chk("rst_press", key_press, 0);
    chk("rst_release", key_release, 0);
    chk("rst_count", press_count, 0);
    reset = 1'b0;
    idle(2);
    key = 4'b1110;
    measure(0, n);
    chk("press_latency", n, D + 2);
    @(negedge clk);
    chk("held_level0", key_level[0], 1'b1);
    chk("count0_one", press_count[CW-1:0], 1);
    key = '1;
    idle(12);
    key[0] = 1'b0; idle(3); key[0] = 1'b1; idle(10);
    key[0] = 1'b0; idle(10);
    key[0] = 1'b1; idle(2); key[0] = 1'b0; idle(8);
    key[0] = 1'b1; idle(12);
    repeat_en = 1'b1; key[1] = 1'b0; idle(40);
    repeat_en = 1'b0; idle(10);
    chk("hold_after_repeat", key_level[1], 1'b1);
    key[1] = 1'b1; idle(12);
    repeat (17) begin
      key[2] = 1'b0; idle(8);
      key[2] = 1'b1; idle(8);
    end
    chk("wrap_count2", press_count[2*CW +: CW], 1);
    idle(4);
    key = 4'b0000;
    n = 0;
    while (n < 20 && key_press == '0) begin
      @(posedge clk); #1; n++;
    end
    chk("simultaneous", key_press, 4'hF);
    repeat_en = 1'b1;
    idle(25);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    measure(3, n);
    chk("post_reset_latency", n, D + 2);
    repeat_en = 1'b0;
    key = '1;
    idle(12);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, (c / 300) % 2 ? 29 : 5) == 0) key[i] = ~key[i];
    end
    reset = 1'b0;
    key = '1;
    idle(15);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
